updown_counter_param: RTL and testbench

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/counter_pkg.sv | 5 +
 rtl/button_sync_edge.sv | 39 +++
 rtl/updown_counter_param.sv | 52 +++++
 tb/tb_updown_counter_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction state type and default counter width
package counter_pkg;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/button_sync_edge.sv
// button_sync_edge: 2-flop synchroniser and rising-edge pulse; COUNTER_DEBOUNCE_EN inserts a stable-sample filter
module button_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync;
  logic lvl, lvl_d;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  always_ff @(posedge clk) begin
    sync  <= clr ? 2'b00 : {sync[0], btn};
    lvl_d <= clr ? 1'b0 : lvl;
  end
`ifdef COUNTER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic filt;
  // The filtered level flips only once the synchronised input has disagreed with it for DEBOUNCE_CYCLES samples in a row
  always_ff @(posedge clk) begin
    if (clr) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (sync[1] == filt) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      filt <= sync[1];
      cnt  <= '0;
    end else cnt <= cnt + 1'b1;
  end
  assign lvl = filt;
`else
  assign lvl = sync[1];
`endif
  assign pulse = lvl & ~lvl_d;
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: wrapping up/down counter with load, terminal-count pulse and button-toggled direction
// Define COUNTER_DEBOUNCE_EN to debounce the choose button.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int              WIDTH           = DEFAULT_WIDTH,
  parameter longint unsigned MAX_COUNT       = (64'd1 << WIDTH) - 64'd1,
  parameter int              DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             choose,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAXV = MAX_COUNT[WIDTH-1:0];
  if (MAX_COUNT >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("MAX_COUNT does not fit in WIDTH bits");
  end
  dir_t state, state_nx;
  logic pulse, wrap;
  button_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_choose (
    .clk  (clk),
    .clr  (clr),
    .btn  (choose),
    .pulse(pulse)
  );
  always_ff @(posedge clk) state <= clr ? DIR_UP : state_nx;
  always_comb begin
    state_nx = state;
    if (pulse && enable) state_nx = (state == DIR_UP) ? DIR_DOWN : DIR_UP;
  end
  assign dir  = (state == DIR_DOWN);
  assign wrap = dir ? (q == '0) : (q == MAXV);
  // Counting uses the registered direction, so a toggle on the same edge affects only the following step
  always_ff @(posedge clk) begin
    if (clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= (data > MAXV) ? MAXV : data;
      tc <= 1'b0;
    end else if (enable) begin
      q  <= wrap ? (dir ? MAXV : '0) : (dir ? q - 1'b1 : q + 1'b1);
      tc <= wrap;
    end else tc <= 1'b0;
  end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed and randomized checks of the counter against a behavioural model
module tb_updown_counter_param;
  localparam int MAXC = 9;
  localparam int D = 4;
`ifdef COUNTER_DEBOUNCE_EN
  localparam int LAT = 3 + D;
  localparam int PW = D;
`else
  localparam int LAT = 3;
  localparam int PW = 1;
`endif
  logic clk = 0, clr = 1, enable = 0, load = 0, choose = 0;
  logic [7:0] data = 0;
  logic [7:0] q;
  logic dir, tc;
  int checks = 0, errors = 0;

  updown_counter_param #(.WIDTH(8), .MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .clr(clr), .enable(enable), .load(load), .data(data),
    .choose(choose), .q(q), .dir(dir), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: choose samples kept in a queue; the accepted level is a delayed (and optionally filtered) copy
  int mq, mdir, mtc;
  bit m_valid = 0;
  int ch[$];
  int svq[$];
  int lvl, lvl_p;
  always @(posedge clk) begin
    if (clr) begin
      mq = 0; mdir = 0; mtc = 0; lvl = 0; lvl_p = 0; m_valid = 1;
      ch = '{0, 0, 0};
      svq.delete();
      for (int i = 0; i < D; i++) svq.push_back(0);
    end else begin
      automatic int pulse = (lvl == 1 && lvl_p == 0);
      automatic bit same = 1;
      ch.push_back(int'(choose));
      svq.push_back(ch[ch.size() - 3]);
      lvl_p = lvl;
      for (int i = 1; i <= D; i++) if (svq[svq.size() - i] != svq[svq.size() - 1]) same = 0;
`ifdef COUNTER_DEBOUNCE_EN
      if (same) lvl = svq[svq.size() - 1];
`else
      lvl = ch[ch.size() - 2];
`endif
      if (load) begin
        mq = (int'(data) > MAXC) ? MAXC : int'(data);
        mtc = 0;
      end else if (enable) begin
        if (mdir == 0) begin
          mtc = (mq == MAXC);
          mq = mtc ? 0 : mq + 1;
        end else begin
          mtc = (mq == 0);
          mq = mtc ? MAXC : mq - 1;
        end
      end else mtc = 0;
      if (pulse && enable) mdir = 1 - mdir;
      if (ch.size() > 64) void'(ch.pop_front());
      if (svq.size() > 64) void'(svq.pop_front());
    end
  end

  always @(negedge clk) if (m_valid) begin
    chk("model_q", int'(q), mq);
    chk("model_dir", int'(dir), mdir);
    chk("model_tc", int'(tc), mtc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    clr = 0;
    chk("reset_q", int'(q), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_tc", int'(tc), 0);
    enable = 1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("up_seq_q", int'(q), i % 10);
      chk("up_seq_tc", int'(tc), (i == 10) ? 1 : 0);
    end
    load = 1; data = 3; choose = 1;
    step(PW);
    choose = 0;
    step(LAT - PW);
    chk("load3_q", int'(q), 3);
    chk("toggle_dir", int'(dir), 1);
    load = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("down_seq_q", int'(q), (i < 2) ? 2 - i : (i == 2 ? 0 : (i == 3 ? 9 : 8)));
      chk("down_seq_tc", int'(tc), (i == 3) ? 1 : 0);
    end
    enable = 0; load = 1; data = 200;
    step(1);
    chk("load_clamp_q", int'(q), 9);
    data = 5;
    step(1);
    chk("load_noenable_q", int'(q), 5);
    load = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_q", int'(q), 5);
      chk("hold_tc", int'(tc), 0);
    end
    choose = 1;
    step(PW);
    choose = 0;
    step(LAT + 4);
    chk("disabled_choose_dir", int'(dir), 1);
    enable = 1; choose = 1;
    step(20);
    chk("held_choose_dir", int'(dir), 0);
    choose = 0;
    step(LAT + 2);
    chk("held_release_dir", int'(dir), 0);
`ifdef COUNTER_DEBOUNCE_EN
    choose = 1;
    step(2);
    choose = 0;
    step(LAT + 4);
    chk("glitch_dir", int'(dir), 0);
`endif
    load = 1; data = 7; choose = 1;
    step(PW);
    choose = 0;
    step(LAT - PW + 2);
    chk("pre_clr_q", int'(q), 7);
    chk("pre_clr_dir", int'(dir), 1);
    choose = 1;
    step(PW);
    choose = 0;
    step(LAT - PW - 1);
    chk("pending_dir", int'(dir), 1);
    clr = 1;
    step(1);
    chk("clr_q", int'(q), 0);
    chk("clr_dir", int'(dir), 0);
    chk("clr_tc", int'(tc), 0);
    clr = 0; load = 0;
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 4) != 0);
      data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) choose = ~choose;
      step(1);
    end
    clr = 0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
